ext_domain_power_sequencer: RTL
===============================

// Module: ext_domain_power_sequencer
// PURPOSE
//  Initiator side of the power-switch handshake for one external power domain (e.g. the CGRA).
//  Sequences clock gate, isolation, domain reset and switch request on power-down/up, and waits for the switch-cell ack.
//  Sits between a software-visible request bit and the domain's switch cells; the bench switch-cell model is the responder.
//  Provides busy/status outputs and a sticky ack-timeout error.
// PARAMETERS
//  RESET_POWERED     1   1: reset state is ON (domain powered); 0: reset state is OFF
//  ACK_SYNC_STAGES   2   synchronizer depth on switch_ack_ni (>=2)
//  ISO_SETUP_CYCLES  2   cycles between clock gating and isolation, and between isolation and reset/switch-off (>=1)
//  RST_HOLD_CYCLES   4   cycles domain reset stays asserted with clock running after power-up (>=1)
//  ACK_TIMEOUT       64  max cycles waiting for the synchronized ack before flagging err_o (>=ACK_SYNC_STAGES+1)
// PORTS
//  clk_i           in   1  system clock
//  rst_ni          in   1  asynchronous active-low reset
//  pwr_off_req_i   in   1  level: 1 = domain requested off, 0 = requested on
//  err_clr_i       in   1  single-cycle pulse, clears err_o
//  switch_ack_ni   in   1  async ack from switch cells; follows switch_en_no after switch latency
//  switch_en_no    out  1  switch request, 0 = power applied
//  iso_no          out  1  0 = domain outputs isolated
//  dom_rst_no      out  1  0 = domain held in reset
//  clk_en_o        out  1  1 = domain clock running
//  busy_o          out  1  1 in every state except ON and OFF
//  domain_on_o     out  1  1 only in state ON
//  err_o           out  1  sticky: ack timeout occurred
// BEHAVIOUR
//  Reset (async, rst_ni=0), RESET_POWERED=1: state ON; switch_en_no=0, iso_no=1, dom_rst_no=1, clk_en_o=1,
//   domain_on_o=1, busy_o=0, err_o=0, ack synchronizer flops=0.
//  Reset, RESET_POWERED=0: state OFF; switch_en_no=1, iso_no=0, dom_rst_no=0, clk_en_o=0, domain_on_o=0,
//   busy_o=0, err_o=0, synchronizer flops=1.
//  ack_s = switch_ack_ni after ACK_SYNC_STAGES flops; only ack_s is used.
//  All outputs are registered; each changes on the clock edge entering the state listed.
//  States/transitions (cnt = shared down-counter, loaded on state entry):
//   ON:       pwr_off_req_i=1 -> D_CLK.
//   D_CLK:    clk_en_o=0; cnt=ISO_SETUP_CYCLES; at cnt==0 -> D_ISO.
//   D_ISO:    iso_no=0; cnt=ISO_SETUP_CYCLES; at 0 -> D_SW (dom_rst_no=0 on same edge).
//   D_SW:     switch_en_no=1; wait ack_s==1 -> OFF.
//   OFF:      pwr_off_req_i=0 -> U_SW.
//   U_SW:     switch_en_no=0; wait ack_s==0 -> U_RST.
//   U_RST:    clk_en_o=1, dom_rst_no still 0; cnt=RST_HOLD_CYCLES; at 0 -> U_ISO (dom_rst_no=1).
//   U_ISO:    cnt=ISO_SETUP_CYCLES; at 0 -> ON (iso_no=1).
//  Request sampled only in ON/OFF; changes during a sequence are ignored until it completes, then honoured.
//  Timeout: in D_SW/U_SW a counter starts at entry; if ack not seen after ACK_TIMEOUT cycles, set err_o and
//   advance anyway (fail-forward). Counter saturates; never wraps.
//  err_o: set by timeout, cleared by err_clr_i; simultaneous set and clear -> set wins.
//  Ack already at expected value on entry: still needs ACK_SYNC_STAGES+1 cycles min (no combinational bypass).
//  Glitch on ack outside D_SW/U_SW: ignored.
//  rst_ni low mid-sequence: immediately to reset state/outputs; no partial sequence resumes.
//  Invariant: iso_no=0 whenever dom_rst_no=0 or switch_en_no=1; clk_en_o=0 whenever switch_en_no=1.
// TESTING
//  1 RESET_POWERED=1, ack model latency 15: pwr_off_req_i 0->1 -> clk_en_o=0, +2 iso_no=0, +2 dom_rst_no=0 and
//    switch_en_no=1, OFF reached after ack (15+2 sync+1 cycles); busy_o=1 throughout, err_o=0.
//  2 From OFF, pwr_off_req_i 1->0 -> switch_en_no=0, ack after ~18 cycles, clk_en_o=1, dom_rst_no=1 4 cycles
//    later, iso_no=1 2 cycles later, domain_on_o=1.
//  3 Ack tied to 0 (stuck): power-down -> err_o=1 exactly 64 cycles after D_SW entry, state reaches OFF;
//    err_clr_i pulse -> err_o=0; pulse coinciding with a new timeout -> err_o stays 1.
//  4 Toggle pwr_off_req_i 1->0 two cycles after power-down starts -> full down sequence to OFF, then full up to ON.
//  5 Assert rst_ni low during U_RST -> outputs at reset values in same cycle (async); both RESET_POWERED values.
//  6 Random request/ack-latency (0..40) sweep: isolation/clock invariants hold every cycle.

Source files
------------

// File: rtl/ext_domain_power_sequencer.sv
// ext_domain_power_sequencer
//   Initiator side of the power-switch handshake for one external power domain.
//   On a power-down request the clock is gated, then outputs are isolated, then the domain is put
//   in reset and the switch is opened; on power-up the switch is closed, the clock restarts with
//   the domain held in reset, reset is released and finally isolation is removed. Each switch
//   transition waits for the synchronized switch-cell ack, with a fail-forward timeout that sets
//   a sticky error flag.
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   pwr_off_req_i  level request: 1 = domain off, 0 = domain on
//   err_clr_i      single-cycle pulse clearing err_o
//   switch_ack_ni  asynchronous ack from the switch cells (follows switch_en_no)
//   switch_en_no   switch request, 0 = power applied
//   iso_no         0 = domain outputs isolated
//   dom_rst_no     0 = domain held in reset
//   clk_en_o       1 = domain clock running
//   busy_o         1 while a sequence is in progress
//   domain_on_o    1 only when the domain is fully on
//   err_o          sticky ack-timeout flag
`timescale 1ns/1ps
module ext_domain_power_sequencer #(
    parameter bit          RESET_POWERED    = 1'b1,
    parameter int unsigned ACK_SYNC_STAGES  = 2,
    parameter int unsigned ISO_SETUP_CYCLES = 2,
    parameter int unsigned RST_HOLD_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT      = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_off_req_i,
    input  logic err_clr_i,
    input  logic switch_ack_ni,
    output logic switch_en_no,
    output logic iso_no,
    output logic dom_rst_no,
    output logic clk_en_o,
    output logic busy_o,
    output logic domain_on_o,
    output logic err_o
);

    localparam logic [2:0] StOn   = 3'd0;
    localparam logic [2:0] StDClk = 3'd1;
    localparam logic [2:0] StDIso = 3'd2;
    localparam logic [2:0] StDSw  = 3'd3;
    localparam logic [2:0] StOff  = 3'd4;
    localparam logic [2:0] StUSw  = 3'd5;
    localparam logic [2:0] StURst = 3'd6;
    localparam logic [2:0] StUIso = 3'd7;

    localparam logic [2:0] ResetState = RESET_POWERED ? StOn : StOff;

    localparam int unsigned CntMax0 =
        (ISO_SETUP_CYCLES > RST_HOLD_CYCLES) ? ISO_SETUP_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned CntMax  = (ACK_TIMEOUT > CntMax0) ? ACK_TIMEOUT : CntMax0;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    // The counter is loaded with dwell-1 so a state lasts exactly its configured number of cycles.
    localparam logic [CntW-1:0] IsoLoad = CntW'(ISO_SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] RstLoad = CntW'(RST_HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] TmoLoad = CntW'(ACK_TIMEOUT - 1);
    // Ack is only trusted once ACK_SYNC_STAGES+1 cycles have elapsed in a switch state, so a value
    // left in the synchronizer from before the request cannot complete the handshake early.
    localparam logic [CntW-1:0] AckOkMax = CntW'(ACK_TIMEOUT - ACK_SYNC_STAGES - 1);

    logic [ACK_SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]                 state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d, cnt_dec;
    logic                       sw_en_q, sw_en_d;
    logic                       iso_q, iso_d;
    logic                       drst_q, drst_d;
    logic                       clk_en_q, clk_en_d;
    logic                       busy_q, busy_d;
    logic                       on_q, on_d;
    logic                       err_q, err_d;
    logic                       err_set;
    logic                       ack_s;
    logic                       ack_ok;

    always_comb begin
        sync_d = {sync_q[ACK_SYNC_STAGES-2:0], switch_ack_ni};
    end

    assign ack_s   = sync_q[ACK_SYNC_STAGES-1];
    assign ack_ok  = (cnt_q <= AckOkMax);
    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            StOn: begin
                if (pwr_off_req_i) begin
                    state_d = StDClk;
                    cnt_d   = IsoLoad;
                end
            end
            StDClk: begin
                if (cnt_q == '0) begin
                    state_d = StDIso;
                    cnt_d   = IsoLoad;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StDIso: begin
                if (cnt_q == '0) begin
                    state_d = StDSw;
                    cnt_d   = TmoLoad;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StDSw: begin
                if (ack_ok && ack_s) begin
                    state_d = StOff;
                end else if (cnt_q == '0) begin
                    err_set = 1'b1;
                    state_d = StOff;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StOff: begin
                if (!pwr_off_req_i) begin
                    state_d = StUSw;
                    cnt_d   = TmoLoad;
                end
            end
            StUSw: begin
                if (ack_ok && !ack_s) begin
                    state_d = StURst;
                    cnt_d   = RstLoad;
                end else if (cnt_q == '0) begin
                    err_set = 1'b1;
                    state_d = StURst;
                    cnt_d   = RstLoad;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StURst: begin
                if (cnt_q == '0) begin
                    state_d = StUIso;
                    cnt_d   = IsoLoad;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StUIso: begin
                if (cnt_q == '0) begin
                    state_d = StOn;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the entry edge.
    always_comb begin
        sw_en_d  = 1'b0;
        iso_d    = 1'b0;
        drst_d   = 1'b0;
        clk_en_d = 1'b0;
        busy_d   = 1'b1;
        on_d     = 1'b0;
        case (state_d)
            StOn: begin
                iso_d    = 1'b1;
                drst_d   = 1'b1;
                clk_en_d = 1'b1;
                busy_d   = 1'b0;
                on_d     = 1'b1;
            end
            StDClk: begin
                iso_d  = 1'b1;
                drst_d = 1'b1;
            end
            StDIso: begin
                drst_d = 1'b1;
            end
            StDSw: begin
                sw_en_d = 1'b1;
            end
            StOff: begin
                sw_en_d = 1'b1;
                busy_d  = 1'b0;
            end
            StUSw: begin
            end
            StURst: begin
                clk_en_d = 1'b1;
            end
            StUIso: begin
                drst_d   = 1'b1;
                clk_en_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Set has priority over clear.
    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= {ACK_SYNC_STAGES{~RESET_POWERED}};
            state_q  <= ResetState;
            cnt_q    <= '0;
            sw_en_q  <= ~RESET_POWERED;
            iso_q    <= RESET_POWERED;
            drst_q   <= RESET_POWERED;
            clk_en_q <= RESET_POWERED;
            busy_q   <= 1'b0;
            on_q     <= RESET_POWERED;
            err_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sw_en_q  <= sw_en_d;
            iso_q    <= iso_d;
            drst_q   <= drst_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            on_q     <= on_d;
            err_q    <= err_d;
        end
    end

    assign switch_en_no = sw_en_q;
    assign iso_no       = iso_q;
    assign dom_rst_no   = drst_q;
    assign clk_en_o     = clk_en_q;
    assign busy_o       = busy_q;
    assign domain_on_o  = on_q;
    assign err_o        = err_q;

endmodule
